// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and header field positions for spi_cmd_sequencer
package spi_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WDATA = 3'd1,
      ST_RREQ  = 3'd2,
      ST_RWAIT = 3'd3,
      ST_RDATA = 3'd4
   } state_t;

   // Header byte: bit 7 selects write (1) or read (0); low bits carry the start address
   localparam int RW_BIT = 7;

endpackage

// File: rtl/byte_lane_mux.sv
// rtl/byte_lane_mux.sv - byte-lane extract and insert on a multi-byte word selected by index
module byte_lane_mux #(
   parameter int DATA_BYTES = 4,
   parameter int IDX_W      = 2
) (
   input  logic [8*DATA_BYTES-1:0] word,
   input  logic [IDX_W-1:0]        index,
   input  logic [7:0]              ins_byte,
   output logic [7:0]              ext_byte,
   output logic [8*DATA_BYTES-1:0] ins_word
);

   // Lane 0 is bits 7:0 (little-endian); out-of-range index extracts zero and inserts nothing
   always_comb begin
      ext_byte = 8'h00;
      ins_word = word;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (index == IDX_W'(i)) begin
            ext_byte          = word[8*i +: 8];
            ins_word[8*i +: 8] = ins_byte;
         end
      end
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI command frame to register bus sequencer with burst read/write
module spi_cmd_sequencer
   import spi_pkg::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_W     = 7
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    csn,
   input  logic [7:0]              rx_byte,
   input  logic                    rx_valid,
   output logic [7:0]              tx_byte,
   output logic [ADDR_W-1:0]       reg_addr,
   output logic [8*DATA_BYTES-1:0] reg_wdata,
   output logic                    reg_we,
   output logic                    reg_re,
   input  logic [8*DATA_BYTES-1:0] reg_rdata,
   output logic                    busy,
   output logic [7:0]              err_cnt
);

   localparam int W     = 8 * DATA_BYTES;
   localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [W-1:0]      wdata_q, wdata_d;
   logic [W-1:0]      shadow_q, shadow_d;
   logic [7:0]        tx_q, tx_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic [7:0]        err_q, err_d;
   logic              err_inc;

   logic [W-1:0]      mux_word;
   logic [IDX_W-1:0]  mux_idx;
   logic [7:0]        mux_ext;
   logic [W-1:0]      mux_ins;

   // One lane mux serves both directions: it inserts into the write word, or fetches the next read byte
   always_comb begin
      mux_word = (state_q == ST_RDATA) ? shadow_q : wdata_q;
      mux_idx  = (state_q == ST_RDATA) ? idx_q + IDX_W'(1) : idx_q;
   end

   byte_lane_mux #(
      .DATA_BYTES (DATA_BYTES),
      .IDX_W      (IDX_W)
   ) u_lane (
      .word     (mux_word),
      .index    (mux_idx),
      .ins_byte (rx_byte),
      .ext_byte (mux_ext),
      .ins_word (mux_ins)
   );

   // Next-state and registered-output logic; strobes are flops so rx_valid never reaches reg_we combinationally
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      shadow_d = shadow_q;
      tx_d     = 8'h00;
      we_d     = 1'b0;
      re_d     = 1'b0;
      err_inc  = 1'b0;

      // Burst writes advance the address once the write pulse has been issued
      if (we_q) addr_d = addr_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && !csn) begin
               addr_d = rx_byte[ADDR_W-1:0];
               idx_d  = '0;
               if (rx_byte[RW_BIT]) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d = ST_RREQ;
                  re_d    = 1'b1;
               end
            end
         end
         ST_WDATA: begin
            if (rx_valid) begin
               wdata_d = mux_ins;
               if (idx_q == LAST_IDX) begin
                  we_d  = 1'b1;
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            // A byte arriving with the csn rise is taken first; only a still-partial word is an error
            if (csn) begin
               state_d = ST_IDLE;
               if (idx_d != '0) err_inc = 1'b1;
               idx_d = '0;
            end
         end
         ST_RREQ: begin
            if (rx_valid) err_inc = 1'b1;
            state_d = csn ? ST_IDLE : ST_RWAIT;
         end
         ST_RWAIT: begin
            if (rx_valid) err_inc = 1'b1;
            if (csn) begin
               state_d = ST_IDLE;
            end else begin
               shadow_d = reg_rdata;
               tx_d     = reg_rdata[7:0];
               state_d  = ST_RDATA;
            end
         end
         ST_RDATA: begin
            tx_d = tx_q;
            if (rx_valid) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  addr_d  = addr_q + ADDR_W'(1);
                  tx_d    = 8'h00;
                  state_d = ST_RREQ;
                  re_d    = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  tx_d  = mux_ext;
               end
            end
            if (csn) begin
               state_d = ST_IDLE;
               re_d    = 1'b0;
               tx_d    = 8'h00;
               if (idx_d != '0) err_inc = 1'b1;
               idx_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase

      err_d = err_q;
      if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         shadow_q <= '0;
         tx_q     <= 8'h00;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         err_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         shadow_q <= shadow_d;
         tx_q     <= tx_d;
         we_q     <= we_d;
         re_q     <= re_d;
         err_q    <= err_d;
      end
   end

   // Output mapping
   always_comb begin
      tx_byte   = tx_q;
      reg_addr  = addr_q;
      reg_wdata = wdata_q;
      reg_we    = we_q;
      reg_re    = re_q;
      busy      = (state_q != ST_IDLE);
      err_cnt   = err_q;
   end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

   logic        clk;
   logic        rstn;
   logic        csn;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [7:0]  tx_byte;
   logic [6:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [31:0] reg_rdata;
   logic        busy;
   logic [7:0]  err_cnt;

   int checks   = 0;
   int failures = 0;

   spi_cmd_sequencer #(.DATA_BYTES(4), .ADDR_W(7)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .csn       (csn),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .tx_byte   (tx_byte),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   initial begin
      rstn      = 1'b0;
      csn       = 1'b1;
      rx_byte   = 8'h00;
      rx_valid  = 1'b0;
      reg_rdata = 32'hDEADBEEF;
      step();
      step();
      check("rst_tx",    64'(tx_byte),   64'h0);
      check("rst_addr",  64'(reg_addr),  64'h0);
      check("rst_wdata", 64'(reg_wdata), 64'h0);
      check("rst_we",    64'(reg_we),    64'h0);
      check("rst_re",    64'(reg_re),    64'h0);
      check("rst_busy",  64'(busy),      64'h0);
      check("rst_err",   64'(err_cnt),   64'h0);
      rstn = 1'b1;
      step();

      // Single write: header 85, bytes 11 22 33 44
      csn = 1'b0;
      send(8'h85);
      check("wr_busy", 64'(busy), 64'h1);
      send(8'h11);
      send(8'h22);
      check("wr_no_we_mid", 64'(reg_we), 64'h0);
      send(8'h33);
      send(8'h44);
      check("wr_we",    64'(reg_we),    64'h1);
      check("wr_addr",  64'(reg_addr),  64'h05);
      check("wr_wdata", 64'(reg_wdata), 64'h44332211);
      step();
      check("wr_we_one_cycle", 64'(reg_we),   64'h0);
      check("wr_addr_inc",     64'(reg_addr), 64'h06);
      csn = 1'b1;
      step();
      check("wr_idle", 64'(busy),    64'h0);
      check("wr_err",  64'(err_cnt), 64'h0);

      // Burst write across address wrap
      csn = 1'b0;
      send(8'hFF);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      check("bw_we0",    64'(reg_we),    64'h1);
      check("bw_addr0",  64'(reg_addr),  64'h7F);
      check("bw_wdata0", 64'(reg_wdata), 64'h04030201);
      send(8'h05); send(8'h06); send(8'h07); send(8'h08);
      check("bw_we1",    64'(reg_we),    64'h1);
      check("bw_addr1",  64'(reg_addr),  64'h00);
      check("bw_wdata1", 64'(reg_wdata), 64'h08070605);
      csn = 1'b1;
      step();
      check("bw_err", 64'(err_cnt), 64'h0);

      // Read: header 03, four dummy bytes shift out DEADBEEF little-endian
      csn = 1'b0;
      send(8'h03);
      check("rd_re_latency", 64'(reg_re),   64'h1);
      check("rd_addr",       64'(reg_addr), 64'h03);
      check("rd_we_excl",    64'(reg_we),   64'h0);
      check("rd_tx_pre",     64'(tx_byte),  64'h00);
      step();
      check("rd_re_one_cycle", 64'(reg_re), 64'h0);
      step();
      check("rd_tx0", 64'(tx_byte), 64'hEF);
      send(8'h00);
      check("rd_tx1", 64'(tx_byte), 64'hBE);
      send(8'h00);
      check("rd_tx2", 64'(tx_byte), 64'hAD);
      send(8'h00);
      check("rd_tx3", 64'(tx_byte), 64'hDE);
      send(8'h00);
      check("rd_next_re",   64'(reg_re),   64'h1);
      check("rd_next_addr", 64'(reg_addr), 64'h04);
      csn = 1'b1;
      step();
      check("rd_idle", 64'(busy),    64'h0);
      check("rd_err",  64'(err_cnt), 64'h0);

      // Abort mid-word: header 81, two bytes, then csn high
      csn = 1'b0;
      send(8'h81);
      send(8'hAA);
      send(8'hBB);
      csn = 1'b1;
      step();
      check("ab_we",   64'(reg_we),  64'h0);
      check("ab_busy", 64'(busy),    64'h0);
      check("ab_err",  64'(err_cnt), 64'h1);

      // Last write byte coincident with csn rise
      csn = 1'b0;
      send(8'h82);
      send(8'hA1); send(8'hB2); send(8'hC3);
      rx_byte  = 8'hD4;
      rx_valid = 1'b1;
      csn      = 1'b1;
      step();
      rx_valid = 1'b0;
      check("edge_we",    64'(reg_we),    64'h1);
      check("edge_addr",  64'(reg_addr),  64'h02);
      check("edge_wdata", 64'(reg_wdata), 64'hD4C3B2A1);
      check("edge_idle",  64'(busy),      64'h0);
      check("edge_err",   64'(err_cnt),   64'h1);

      // Host too fast: byte during RREQ is ignored and counted
      step();
      csn = 1'b0;
      send(8'h10);
      send(8'h55);
      check("fast_err", 64'(err_cnt), 64'h2);
      csn = 1'b1;
      step();
      check("fast_idle", 64'(busy), 64'h0);

      // Asynchronous reset in the middle of a read burst
      csn = 1'b0;
      send(8'h01);
      step();
      step();
      send(8'h00);
      check("ar_tx_before", 64'(tx_byte), 64'hBE);
      #2;
      rstn = 1'b0;
      #1;
      check("ar_tx",    64'(tx_byte),   64'h0);
      check("ar_addr",  64'(reg_addr),  64'h0);
      check("ar_wdata", 64'(reg_wdata), 64'h0);
      check("ar_re",    64'(reg_re),    64'h0);
      check("ar_we",    64'(reg_we),    64'h0);
      check("ar_busy",  64'(busy),      64'h0);
      check("ar_err",   64'(err_cnt),   64'h0);
      csn = 1'b1;
      step();
      rstn = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
